can_uart_formatter: RTL and testbench

Converts each received CAN frame (11-bit ID, DLC, 8 data bytes) into three 8-character ASCII lines and hands them one at a time to the downstream `uart_tx`, which appends CR to each line. The block sits between the CAN receive path and `uart_tx`. It drives `uart_start` and the 64-bit `rx_data` word that `uart_tx` consumes. `uart_tx` has no busy output, so this block paces lines with a fixed line-time counter. It holds one pending frame while a frame is being printed.

---
 rtl/can_uart_formatter_if.sv | 20 ++
 rtl/can_uart_formatter.sv | 136 +++++++++++++
 tb/tb_can_uart_formatter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/can_uart_formatter_if.sv
// Frame input and line output bundle between the CAN receive path, the formatter and uart_tx.
`timescale 1ns/1ps
interface can_uart_formatter_if;
    logic        frame_valid;
    logic [10:0] can_id;
    logic [3:0]  can_dlc;
    logic [63:0] can_data;
    logic [63:0] tx_data;
    logic [1:0]  uart_start;

    modport master (
        output frame_valid, can_id, can_dlc, can_data,
        input  tx_data, uart_start
    );

    modport slave (
        input  frame_valid, can_id, can_dlc, can_data,
        output tx_data, uart_start
    );
endinterface

// File: rtl/can_uart_formatter.sv
// Turns each CAN frame into three 8-character ASCII lines for uart_tx.
// The lines are paced by a fixed line-time counter, and one further frame can wait in a pending buffer.
`timescale 1ns/1ps
module can_uart_formatter #(
    parameter int LINE_CYCLES = 108500
) (
    input  logic                clk,
    input  logic                rst,
    can_uart_formatter_if.slave bus,
    output logic                busy,
    output logic [7:0]          drop_cnt
);
    localparam int CW = $clog2(LINE_CYCLES) + 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(LINE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t state;

    logic          pend_valid;
    logic [10:0]   pend_id;
    logic [3:0]    pend_dlc;
    logic [63:0]   pend_data;

    logic [10:0]   id;
    logic [3:0]    dlc_c;
    logic [63:0]   data;
    logic [1:0]    line_idx;
    logic [CW-1:0] cnt;

    logic [63:0]   tx_data;
    logic [1:0]    uart_start;
    logic [63:0]   line_text;
    logic          consume;
    logic          accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Bytes beyond the clamped DLC print as "--".
    function automatic logic [15:0] byte_text(input logic [7:0] b, input logic [3:0] idx,
                                              input logic [3:0] dlc);
        if (idx < dlc)
            return {hex_char(b[7:4]), hex_char(b[3:0])};
        return 16'h2D2D;
    endfunction

    always_comb begin
        line_text = '0;
        case (line_idx)
            2'd0: line_text = {8'h49, hex_char({1'b0, id[10:8]}), hex_char(id[7:4]),
                               hex_char(id[3:0]), 8'h20, 8'h4C, hex_char(dlc_c), 8'h20};
            2'd1: begin
                for (int i = 0; i < 4; i++)
                    line_text[63-16*i -: 16] = byte_text(data[63-8*i -: 8], 4'(i), dlc_c);
            end
            default: begin
                for (int i = 0; i < 4; i++)
                    line_text[63-16*i -: 16] = byte_text(data[31-8*i -: 8], 4'(i + 4), dlc_c);
            end
        endcase
    end

    // A strobe may refill the buffer in the same cycle that IDLE empties it.
    assign consume = (state == IDLE) && pend_valid;
    assign accept  = bus.frame_valid && (!pend_valid || consume);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_id    <= '0;
            pend_dlc   <= '0;
            pend_data  <= '0;
            id         <= '0;
            dlc_c      <= '0;
            data       <= '0;
            line_idx   <= '0;
            cnt        <= '0;
            tx_data    <= '0;
            uart_start <= 2'b00;
            busy       <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            uart_start <= 2'b00;

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        id       <= pend_id;
                        dlc_c    <= (pend_dlc > 4'd8) ? 4'd8 : pend_dlc;
                        data     <= pend_data;
                        line_idx <= 2'd0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_data    <= line_text;
                    uart_start <= 2'b01;
                    cnt        <= WAIT_LOAD;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (line_idx < 2'd2) begin
                            line_idx <= line_idx + 2'd1;
                            state    <= SEND;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                pend_valid <= 1'b1;
                pend_id    <= bus.can_id;
                pend_dlc   <= bus.can_dlc;
                pend_data  <= bus.can_data;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end

            if (bus.frame_valid && !accept && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.tx_data    = tx_data;
    assign bus.uart_start = uart_start;
endmodule

// File: tb/tb_can_uart_formatter.sv
// Scoreboard bench for can_uart_formatter with LINE_CYCLES=20.
// Stimulus queues the expected lines, and a monitor checks each uart_start pulse against them.
`timescale 1ns/1ps
module tb_can_uart_formatter;
    localparam int LC = 20;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] drop_cnt;

    can_uart_formatter_if bus ();

    can_uart_formatter #(.LINE_CYCLES(LC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [63:0] line;
        int          gap;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_pulse = 0;
    logic [1:0] prev_start = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic expect_line(input string name, input logic [63:0] line, input int gap);
        exp_t e;
        e.line = line;
        e.gap  = gap;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic expect_frame(input string name, input logic [63:0] l0, input logic [63:0] l1,
                                input logic [63:0] l2, input int first_gap);
        expect_line({name, "_l0"}, l0, first_gap);
        expect_line({name, "_l1"}, l1, LC);
        expect_line({name, "_l2"}, l2, LC);
    endtask

    // Called at a negedge; the strobe is captured by the next posedge.
    task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] d);
        bus.frame_valid = 1'b1;
        bus.can_id      = id;
        bus.can_dlc     = dlc;
        bus.can_data    = d;
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    task automatic latency_check(input string name);
        check_output({name, "_busy_pre"}, 64'(busy), 64'h0);
        @(negedge clk);
        check_output({name, "_busy_k1"}, 64'(busy), 64'h1);
        @(negedge clk);
        check_output({name, "_start_k2"}, 64'(bus.uart_start), 64'h1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("[TB] FAIL %s_timeout: %0d lines outstanding, busy=%b, required drained and idle",
                     name, exp_q.size(), busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_tx_data"}, bus.tx_data, 64'h0);
        check_output({name, "_start"}, 64'(bus.uart_start), 64'h0);
        check_output({name, "_busy"}, 64'(busy), 64'h0);
        check_output({name, "_drop"}, 64'(drop_cnt), 64'h0);
    endtask

    // Monitor: every pulse must match the next queued line and its spacing.
    always @(negedge clk) begin
        exp_t e;
        if (bus.uart_start !== 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: uart_start=%b tx_data=%h at cycle %0d, required no pulse",
                         bus.uart_start, bus.tx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output({e.name, "_data"}, bus.tx_data, e.line);
                check_output({e.name, "_start"}, 64'(bus.uart_start), 64'h1);
                check_output({e.name, "_width"}, 64'(prev_start), 64'h0);
                if (e.gap >= 0)
                    check_output({e.name, "_gap"}, 64'(cyc - last_pulse), 64'(e.gap));
            end
            last_pulse = cyc;
        end
        prev_start = bus.uart_start;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.frame_valid = 1'b0;
        bus.can_id      = '0;
        bus.can_dlc     = '0;
        bus.can_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        expect_frame("full", 64'h49313233204C3820, 64'h4445414442454546, 64'h3031323334353637, -1);
        send_frame(11'h123, 4'd8, 64'hDEADBEEF01234567);
        latency_check("full");
        wait_idle("full");
        check_output("full_tx_hold", bus.tx_data, 64'h3031323334353637);

        expect_frame("short", 64'h49374646204C3220, 64'h414243442D2D2D2D, 64'h2D2D2D2D2D2D2D2D, -1);
        send_frame(11'h7FF, 4'd2, 64'hABCD112233445566);
        wait_idle("short");

        expect_frame("clamp", 64'h49303030204C3820, 64'h3031323334353637, 64'h3839414243444546, -1);
        send_frame(11'h000, 4'd12, 64'h0123456789ABCDEF);
        wait_idle("clamp");

        // Back-to-back: P loads at k+1, Q waits in the buffer, and R arrives exactly when IDLE loads Q at k+62.
        expect_frame("b2b_p", 64'h49313233204C3820, 64'h4445414442454546, 64'h3031323334353637, -1);
        expect_frame("b2b_q", 64'h49374646204C3220, 64'h414243442D2D2D2D, 64'h2D2D2D2D2D2D2D2D, LC + 1);
        expect_frame("b2b_r", 64'h49303030204C3820, 64'h3031323334353637, 64'h3839414243444546, LC + 1);
        send_frame(11'h123, 4'd8, 64'hDEADBEEF01234567);
        repeat (9) @(negedge clk);
        send_frame(11'h7FF, 4'd2, 64'hABCD112233445566);
        repeat (51) @(negedge clk);
        check_output("b2b_busy_gap", 64'(busy), 64'h0);
        send_frame(11'h000, 4'd12, 64'h0123456789ABCDEF);
        check_output("b2b_busy_reload", 64'(busy), 64'h1);
        check_output("b2b_no_drop", 64'(drop_cnt), 64'h0);
        wait_idle("b2b");

        // Overflow: A at k, B at k+1, C dropped at k+2, then F at k+3..k+302; F is accepted at k+62/123/184/245.
        expect_frame("ovf_a", 64'h49303031204C3120, 64'h31312D2D2D2D2D2D, 64'h2D2D2D2D2D2D2D2D, -1);
        expect_frame("ovf_b", 64'h49324142204C3420, 64'h3839414243444546, 64'h2D2D2D2D2D2D2D2D, LC + 1);
        for (int i = 0; i < 4; i++)
            expect_frame("ovf_f", 64'h49364630204C3520, 64'h3041314232433344, 64'h34452D2D2D2D2D2D, LC + 1);
        bus.frame_valid = 1'b1;
        bus.can_id      = 11'h001;
        bus.can_dlc     = 4'd1;
        bus.can_data    = 64'h1111111111111111;
        @(negedge clk);
        bus.can_id   = 11'h2AB;
        bus.can_dlc  = 4'd4;
        bus.can_data = 64'h89ABCDEFFFFFFFFF;
        @(negedge clk);
        check_output("ovf_drop_before", 64'(drop_cnt), 64'h0);
        check_output("ovf_busy", 64'(busy), 64'h1);
        bus.can_id   = 11'h555;
        bus.can_dlc  = 4'd8;
        bus.can_data = 64'h5555555555555555;
        @(negedge clk);
        check_output("ovf_drop_one", 64'(drop_cnt), 64'h1);
        bus.can_id   = 11'h6F0;
        bus.can_dlc  = 4'd5;
        bus.can_data = 64'h0A1B2C3D4E5F6071;
        repeat (300) @(negedge clk);
        bus.frame_valid = 1'b0;
        check_output("ovf_drop_sat", 64'(drop_cnt), 64'hFF);
        wait_idle("ovf");
        check_output("ovf_drop_hold", 64'(drop_cnt), 64'hFF);

        // Reset at k+30 lands in the WAIT that follows line 1.
        expect_line("rst_s_l0", 64'h49303031204C3120, -1);
        expect_line("rst_s_l1", 64'h31312D2D2D2D2D2D, LC);
        send_frame(11'h001, 4'd1, 64'h1111111111111111);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        repeat (60) @(negedge clk);
        expect_frame("post_rst", 64'h49313233204C3820, 64'h4445414442454546, 64'h3031323334353637, -1);
        send_frame(11'h123, 4'd8, 64'hDEADBEEF01234567);
        latency_check("post_rst");
        wait_idle("post_rst");

        check_output("leftover_lines", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
